// File: rtl/mem_pkg.sv
// Shared types, widths and address helpers for the SRAM data-memory controller.
package mem_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SRAM_AW = 18;
  localparam int unsigned SRAM_DW = 16;
  localparam int unsigned IDX_W   = SRAM_AW - 1;
  localparam int unsigned WAIT_CW = 4;

  localparam logic [DATA_W-1:0] DEFAULT_BASE_ADDR = 32'd1024;
  // Bytes covered by the SRAM: 2^17 words of 4 bytes.
  localparam logic [DATA_W-1:0] SRAM_SPAN_BYTES   = 32'h0008_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

  // Request captured from the EXE stage for the duration of one access.
  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // Word index of a data-space byte address; wraps modulo the SRAM span.
  function automatic logic [IDX_W-1:0] word_index(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] base);
    logic [DATA_W-1:0] off;
    off = a - base;
    return IDX_W'(off >> 2);
  endfunction

  // True when the address falls outside the SRAM window or is not word aligned.
  function automatic logic addr_is_bad(input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] base);
    logic [DATA_W-1:0] off;
    off = a - base;
    return (a < base) || (off >= SRAM_SPAN_BYTES) || (a[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter that pacifies each SRAM half-access for a fixed number of cycles.
module sram_wait_counter
  import mem_pkg::*;
#(
  parameter int unsigned CW = WAIT_CW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          dec_i,
  output logic          tc_c_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Load takes priority over decrement; the counter saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_c_o = (cnt_q == '0);

endmodule

// File: rtl/mem_sram_ctrl.sv
// Data-memory controller: splits 32-bit loads/stores into two 16-bit SRAM accesses
// and freezes the pipeline (ready=0) until the access completes.
// Optional build macro SRAM_ADDR_CHECK_EN: rejects out-of-window or misaligned
// addresses without touching the SRAM and raises a sticky addr_err output.
module mem_sram_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned       WAIT_CYCLES = 3,
  parameter logic [DATA_W-1:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [DATA_W-1:0]  addr,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_o,
  input  logic [SRAM_DW-1:0] sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_ce_n
`ifdef SRAM_ADDR_CHECK_EN
  ,
  output logic               addr_err
`endif
);

  localparam logic [WAIT_CW-1:0] WAIT_LOAD = WAIT_CW'(WAIT_CYCLES - 1);

  state_e             state_q, state_d;
  mem_req_t           req_q, req_d, req_in;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic [SRAM_DW-1:0] sram_dq_o_q, sram_dq_o_d;
  logic               sram_dq_oe_q, sram_dq_oe_d;
  logic               sram_we_n_q, sram_we_n_d;
  logic               sram_ce_n_q, sram_ce_n_d;
  logic               new_req;
  logic               ready_c;
  logic               cnt_load, cnt_dec, cnt_tc;
  logic [IDX_W-1:0]   idx;
`ifdef SRAM_ADDR_CHECK_EN
  logic               addr_err_q, addr_err_d;
`endif

  // Simultaneous load and store requests resolve to a store.
  assign new_req = mem_r_en | mem_w_en;
  assign req_in  = '{we: mem_w_en, addr: addr, wdata: wdata};

  sram_wait_counter #(
    .CW(WAIT_CW)
  ) u_wait (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (cnt_load),
    .load_val_i (WAIT_LOAD),
    .dec_i      (cnt_dec),
    .tc_c_o     (cnt_tc)
  );

  // Next-state, request capture, read-data capture and handshake.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    rdata_d  = rdata_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    ready_c  = 1'b0;
`ifdef SRAM_ADDR_CHECK_EN
    addr_err_d = addr_err_q;
`endif
    case (state_q)
      IDLE: begin
        ready_c = ~new_req;
        if (new_req) begin
          req_d = req_in;
`ifdef SRAM_ADDR_CHECK_EN
          if (addr_is_bad(addr, BASE_ADDR)) begin
            state_d    = DONE;
            addr_err_d = 1'b1;
            if (!mem_w_en) begin
              rdata_d = '0;
            end
          end else begin
            state_d  = LO;
            cnt_load = 1'b1;
          end
`else
          state_d  = LO;
          cnt_load = 1'b1;
`endif
        end
      end
      LO: begin
        if (cnt_tc) begin
          state_d  = HI;
          cnt_load = 1'b1;
          if (!req_q.we) begin
            rdata_d[15:0] = sram_dq_i;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      HI: begin
        if (cnt_tc) begin
          state_d = DONE;
          if (!req_q.we) begin
            rdata_d[31:16] = sram_dq_i;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE: begin
        ready_c = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // SRAM pins for the upcoming cycle, derived from the next state so they align with it.
  always_comb begin
    sram_addr_d  = '0;
    sram_dq_o_d  = '0;
    sram_dq_oe_d = 1'b0;
    sram_we_n_d  = 1'b1;
    sram_ce_n_d  = 1'b1;
    idx          = word_index(req_d.addr, BASE_ADDR);
    case (state_d)
      LO: begin
        sram_ce_n_d = 1'b0;
        sram_addr_d = {idx, 1'b0};
        if (req_d.we) begin
          sram_we_n_d  = 1'b0;
          sram_dq_oe_d = 1'b1;
          sram_dq_o_d  = req_d.wdata[15:0];
        end
      end
      HI: begin
        sram_ce_n_d = 1'b0;
        sram_addr_d = {idx, 1'b1};
        if (req_d.we) begin
          sram_we_n_d  = 1'b0;
          sram_dq_oe_d = 1'b1;
          sram_dq_o_d  = req_d.wdata[31:16];
        end
      end
      default: begin
        sram_ce_n_d = 1'b1;
      end
    endcase
  end

  // State, captured request, read data and SRAM pin registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      req_q        <= '0;
      rdata_q      <= '0;
      sram_addr_q  <= '0;
      sram_dq_o_q  <= '0;
      sram_dq_oe_q <= 1'b0;
      sram_we_n_q  <= 1'b1;
      sram_ce_n_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      rdata_q      <= rdata_d;
      sram_addr_q  <= sram_addr_d;
      sram_dq_o_q  <= sram_dq_o_d;
      sram_dq_oe_q <= sram_dq_oe_d;
      sram_we_n_q  <= sram_we_n_d;
      sram_ce_n_q  <= sram_ce_n_d;
    end
  end

`ifdef SRAM_ADDR_CHECK_EN
  // Sticky address-error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= addr_err_d;
    end
  end

  assign addr_err = addr_err_q;
`endif

  // ready drops in the same cycle a request arrives; it reads high while held in reset.
  assign ready      = ready_c | ~rst;
  assign rdata      = rdata_q;
  assign sram_addr  = sram_addr_q;
  assign sram_dq_o  = sram_dq_o_q;
  assign sram_dq_oe = sram_dq_oe_q;
  assign sram_we_n  = sram_we_n_q;
  assign sram_ce_n  = sram_ce_n_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl with a small synchronous SRAM model.
module tb_mem_sram_ctrl;

  localparam int unsigned W = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] addr, wdata, rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_we_n, sram_ce_n;
`ifdef SRAM_ADDR_CHECK_EN
  logic        addr_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_sram_ctrl #(
    .WAIT_CYCLES (W),
    .BASE_ADDR   (32'd1024)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_r_en   (mem_r_en),
    .mem_w_en   (mem_w_en),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_i  (sram_dq_i),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n),
    .sram_ce_n  (sram_ce_n)
`ifdef SRAM_ADDR_CHECK_EN
    ,
    .addr_err   (addr_err)
`endif
  );

  // SRAM model: writes on the clock edge, reads combinationally.
  logic [15:0] mem [0:1023];
  logic        pl_en;
  logic [9:0]  pl_a;
  logic [15:0] pl_d;

  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (!sram_ce_n && !sram_we_n) mem[sram_addr[9:0]] <= sram_dq_o;
  end

  assign sram_dq_i = (!sram_ce_n && sram_we_n) ? mem[sram_addr[9:0]] : 16'h0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [15:0] d);
    pl_a  = a;
    pl_d  = d;
    pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issue one request in an IDLE cycle and check every cycle up to DONE.
  task automatic do_access(input logic re, input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [16:0] idx);
    logic        hi;
    logic [15:0] exp_dq;
    mem_r_en = re;
    mem_w_en = we;
    addr     = a;
    wdata    = wd;
    #1;
    check("idle_ce_n", 32'(sram_ce_n), 1);
    check("ready_drop", 32'(ready), 0);
    for (int c = 1; c <= int'(2 * W); c++) begin
      @(negedge clk);
      hi     = (c > int'(W));
      exp_dq = hi ? wd[31:16] : wd[15:0];
      check("ce_n", 32'(sram_ce_n), 0);
      check("sram_addr", 32'(sram_addr), 32'({idx, hi}));
      check("we_n", 32'(sram_we_n), (re && !we) ? 1 : 0);
      check("dq_oe", 32'(sram_dq_oe), we ? 1 : 0);
      if (we) check("dq_o", 32'(sram_dq_o), 32'(exp_dq));
      check("ready_busy", 32'(ready), 0);
    end
    @(negedge clk);
    check("ready_done", 32'(ready), 1);
    check("done_ce_n", 32'(sram_ce_n), 1);
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
  endtask

  initial begin
    rst      = 1'b0;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    addr     = '0;
    wdata    = '0;
    pl_en    = 1'b0;
    pl_a     = '0;
    pl_d     = '0;

    // Reset values
    @(negedge clk);
    check("rst_ready", 32'(ready), 1);
    check("rst_we_n", 32'(sram_we_n), 1);
    check("rst_ce_n", 32'(sram_ce_n), 1);
    check("rst_oe", 32'(sram_dq_oe), 0);
    check("rst_sram_addr", 32'(sram_addr), 0);
    check("rst_dq_o", 32'(sram_dq_o), 0);
    check("rst_rdata", rdata, 0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(ready), 1);

    // Store 0xDEADBEEF at 1024 -> halfwords 0/1
    do_access(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, 17'd0);
    check("st0_mem_lo", 32'(mem[0]), 32'h0000_BEEF);
    check("st0_mem_hi", 32'(mem[1]), 32'h0000_DEAD);
    check("st0_rdata_hold", rdata, 0);
    @(negedge clk);

    // Load 1028 from preloaded words 2/3
    preload(10'd2, 16'h5678);
    preload(10'd3, 16'h1234);
    do_access(1'b1, 1'b0, 32'd1028, 32'h0, 17'd1);
    check("ld1_rdata", rdata, 32'h1234_5678);
    @(negedge clk);

    // Store then load back-to-back at 1040; request held during DONE is ignored
    do_access(1'b0, 1'b1, 32'd1040, 32'hCAFE_F00D, 17'd4);
    mem_r_en = 1'b1;
    addr     = 32'd1040;
    #1;
    check("done_ignores_req", 32'(ready), 1);
    @(negedge clk);
    do_access(1'b1, 1'b0, 32'd1040, 32'h0, 17'd4);
    check("b2b_rdata", rdata, 32'hCAFE_F00D);
    @(negedge clk);

    // Both enables high is a store at 1032 -> halfwords 4/5
    do_access(1'b1, 1'b1, 32'd1032, 32'h0BAD_F00D, 17'd2);
    check("both_mem_lo", 32'(mem[4]), 32'h0000_F00D);
    check("both_mem_hi", 32'(mem[5]), 32'h0000_0BAD);
    check("both_rdata_hold", rdata, 32'hCAFE_F00D);
    @(negedge clk);

    // Reset asserted in the first HI cycle of a store at 1048 -> halfwords 12/13
    preload(10'd12, 16'h0000);
    preload(10'd13, 16'hAAAA);
    mem_w_en = 1'b1;
    addr     = 32'd1048;
    wdata    = 32'h1111_2222;
    repeat (W + 1) @(negedge clk);
    check("rh_sram_addr", 32'(sram_addr), 13);
    check("rh_we_n_pre", 32'(sram_we_n), 0);
    #1 rst = 1'b0;
    #1;
    check("rh_we_n", 32'(sram_we_n), 1);
    check("rh_ce_n", 32'(sram_ce_n), 1);
    check("rh_oe", 32'(sram_dq_oe), 0);
    check("rh_ready", 32'(ready), 1);
    mem_w_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rh_idle_ready", 32'(ready), 1);
    check("rh_idle_ce_n", 32'(sram_ce_n), 1);
    check("rh_mem_lo", 32'(mem[12]), 32'h0000_2222);
    check("rh_mem_hi", 32'(mem[13]), 32'h0000_AAAA);
    check("rh_rdata", rdata, 0);

    // Load 1024 after reset
    do_access(1'b1, 1'b0, 32'd1024, 32'h0, 17'd0);
    check("ld0_rdata", rdata, 32'hDEAD_BEEF);
    @(negedge clk);

`ifdef SRAM_ADDR_CHECK_EN
    // Out-of-window load completes in one cycle without touching the SRAM
    check("err_clear", 32'(addr_err), 0);
    mem_r_en = 1'b1;
    addr     = 32'd1000;
    #1;
    check("err_ready_drop", 32'(ready), 0);
    @(negedge clk);
    check("err_ready", 32'(ready), 1);
    check("err_rdata", rdata, 0);
    check("err_flag", 32'(addr_err), 1);
    check("err_ce_n", 32'(sram_ce_n), 1);
    mem_r_en = 1'b0;
    @(negedge clk);
    check("err_sticky", 32'(addr_err), 1);
    check("err_idle_ce_n", 32'(sram_ce_n), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
